root_up_collector: RTL and testbench
====================================

// Module: root_up_collector
// PURPOSE
//  Root-side upstream merger: accepts NUM_LEAVES independent 64-bit valid/ready leaf->root streams (leaf parent_tx),
//  buffers each in a skid FIFO, round-robin arbitrates them onto one stream for root hub logic and tags the source leaf.
//  Tracks per-round DONE messages from every leaf and pulses all_done once all leaves have reported.
// PARAMETERS
//  NUM_LEAVES    4   number of leaf FPGAs attached below the root (>=2)
//  FIFO_DEPTH    2   entries per leaf FIFO, power of two >=2
//  MSG_TYPE_DONE 8'hFF  value of data[63:56] marking a leaf round-complete message
// PORTS
//  clk          in   1              system clock
//  reset_n      in   1              asynchronous active-low reset
//  up_rx_data   in   64*NUM_LEAVES  leaf i message at [64*i +: 64]
//  up_rx_valid  in   NUM_LEAVES     leaf i message valid
//  up_rx_ready  out  NUM_LEAVES     leaf i FIFO not full
//  out_data     out  64             merged message
//  out_src      out  $clog2(NUM_LEAVES)  leaf index of out_data
//  out_valid    out  1              merged message valid
//  out_ready    in   1              downstream accepts
//  all_done     out  1              1-cycle pulse: DONE received from every leaf this round
// BEHAVIOUR
//  - Reset: FIFOs empty, up_rx_ready all 1 one cycle after release, out_valid=0, out_data=0, out_src=0, rr pointer=0,
//    done_mask=0, all_done=0. Reset asserted mid-transfer discards all buffered data; no partial message survives.
//  - Leaf handshake: transfer when up_rx_valid[i]&up_rx_ready[i]; up_rx_ready[i]=!full[i] (registered count, no comb path
//    from out_ready). Push and pop in the same cycle on a full FIFO is not allowed: ready=0 when full, regardless of pop.
//  - Output: single registered stage. out_valid/out_data/out_src held stable until out_ready. Stage loads when empty or
//    out_ready=1 (full throughput: 1 message/cycle with out_ready tied high). Latency leaf accept -> out_valid: 2 cycles.
//  - Arbitration: grant = first non-empty FIFO at or after rr pointer (wrapping NUM_LEAVES-1 -> 0); on a load, rr <= grant+1
//    mod NUM_LEAVES. No grant when stage is held. Starvation bound: NUM_LEAVES loads.
//  - Done tracking (on the output side, when a message with data[63:56]==MSG_TYPE_DONE is loaded into out stage):
//    done_mask[src] <= 1. Duplicate DONE from a leaf already set: forwarded, mask unchanged. When mask becomes all-ones,
//    all_done=1 for exactly one cycle (registered, same cycle out_valid shows that last DONE) and done_mask clears to 0
//    in that cycle; a DONE loaded the next cycle starts the new round. DONE messages are always forwarded on out_*.
//  - FIFO wrap: read/write pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  ROOT_UP_COLLECTOR_STATS_EN defined: adds outputs stat_msgs (32*NUM_LEAVES, per-leaf forwarded-message count) and
//    stat_stall (32, cycles out_valid&!out_ready); counters saturate at 32'hFFFF_FFFF, reset to 0 by reset_n.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package (root_link_pkg): LINK_DATA_W=64, MSG_TYPE_MSB=63, MSG_TYPE_LSB=56, MSG_TYPE_DONE, link_msg_t typedef.
//  Sub-module: link_skid_fifo (one per leaf, generate loop; valid/ready in, valid/ready out, FIFO_DEPTH param).
//  Arbiter, output stage, done tracker and stats inline in root_up_collector.
// TESTING
//  1. Reset: drive reset_n=0 with all valids high -> out_valid=0, all_done=0; after release up_rx_ready=4'hF.
//  2. Single leaf 2 sends 64'h0000_0000_0000_00A5, out_ready=1 -> 2 cycles later out_valid=1, out_data=..A5, out_src=2.
//  3. All 4 leaves valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1,... one message per cycle.
//  4. out_ready=0 for 10 cycles, leaves stream -> each FIFO fills to 2, up_rx_ready=0, out_* stable; release -> no loss,
//     per-leaf order preserved.
//  5. DONE (8'hFF top byte) from leaves 3,1,1,0,2 -> all_done pulses once, on cycle leaf 2's DONE appears on out_*; mask=0 after.
//  6. Assert reset_n=0 with full FIFOs mid-stream -> after release no stale message emitted, done_mask=0.

Source files
------------

// File: rtl/root_link_pkg.sv
// Shared leaf<->root link definitions: message width, message-type field
// position, DONE message type and a field accessor.
package root_link_pkg;

    localparam int unsigned LINK_DATA_W   = 64;
    localparam int unsigned MSG_TYPE_MSB  = 63;
    localparam int unsigned MSG_TYPE_LSB  = 56;
    localparam logic [7:0]  MSG_TYPE_DONE = 8'hFF;

    typedef logic [LINK_DATA_W-1:0] link_msg_t;

    // Extracts the message-type byte from a link message.
    function automatic logic [MSG_TYPE_MSB-MSG_TYPE_LSB:0] msg_type(input link_msg_t msg);
        return msg[MSG_TYPE_MSB:MSG_TYPE_LSB];
    endfunction

endpackage

// File: rtl/link_skid_fifo.sv
// Per-leaf skid FIFO. in_ready is a flop derived from the next occupancy,
// so there is no combinational path from the read side to the write side;
// a full FIFO never accepts, even when it is popped in the same cycle.
module link_skid_fifo
    import root_link_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = LINK_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (natural power-of-two wrap) and occupancy.
    always_comb begin
        push     = in_valid && in_ready_q;
        pop      = out_valid && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    // State registers; reset empties the FIFO and holds in_ready low until release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/root_up_collector.sv
// Root-side upstream merger: one skid FIFO per leaf, round-robin merge into a
// single registered output stage tagged with the source leaf, and per-round
// DONE tracking that pulses all_done once every leaf has reported.
// Optional statistics outputs are enabled by ROOT_UP_COLLECTOR_STATS_EN.
module root_up_collector
    import root_link_pkg::LINK_DATA_W;
    import root_link_pkg::link_msg_t;
    import root_link_pkg::msg_type;
#(
    parameter int unsigned NUM_LEAVES    = 4,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter logic [7:0]  MSG_TYPE_DONE = 8'hFF,
    localparam int unsigned SRC_W        = $clog2(NUM_LEAVES)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [LINK_DATA_W*NUM_LEAVES-1:0] up_rx_data,
    input  logic [NUM_LEAVES-1:0]             up_rx_valid,
    output logic [NUM_LEAVES-1:0]             up_rx_ready,
    output logic [LINK_DATA_W-1:0]            out_data,
    output logic [SRC_W-1:0]                  out_src,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              all_done
`ifdef ROOT_UP_COLLECTOR_STATS_EN
    ,
    output logic [32*NUM_LEAVES-1:0]          stat_msgs,
    output logic [31:0]                       stat_stall
`endif
);

    link_msg_t             fifo_data [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] fifo_valid;
    logic [NUM_LEAVES-1:0] fifo_pop;

    logic [SRC_W-1:0]      grant;
    logic                  grant_found;
    logic                  load;
    logic                  take;
    link_msg_t             sel_data;
    logic [NUM_LEAVES-1:0] mask_set;

    logic                  out_valid_q, out_valid_d;
    link_msg_t             out_data_q, out_data_d;
    logic [SRC_W-1:0]      out_src_q, out_src_d;
    logic [SRC_W-1:0]      rr_q, rr_d;
    logic [NUM_LEAVES-1:0] done_mask_q, done_mask_d;
    logic                  all_done_q, all_done_d;

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_leaf
        link_skid_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .DATA_W (LINK_DATA_W)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_data   (up_rx_data[LINK_DATA_W*g +: LINK_DATA_W]),
            .in_valid  (up_rx_valid[g]),
            .in_ready  (up_rx_ready[g]),
            .out_data  (fifo_data[g]),
            .out_valid (fifo_valid[g]),
            .out_ready (fifo_pop[g])
        );
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign all_done  = all_done_q;

    // Round-robin grant: first non-empty FIFO at or after the rr pointer.
    always_comb begin
        int unsigned idx;
        logic [SRC_W-1:0] idx_src;
        idx         = 0;
        idx_src     = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < NUM_LEAVES; k++) begin
            idx     = (32'(rr_q) + k) % NUM_LEAVES;
            idx_src = SRC_W'(idx);
            if (!grant_found && fifo_valid[idx_src]) begin
                grant_found = 1'b1;
                grant       = idx_src;
            end
        end
    end

    // Output stage load, FIFO pop, rr advance and DONE round tracking.
    always_comb begin
        load        = !out_valid_q || out_ready;
        take        = load && grant_found;
        sel_data    = fifo_data[grant];
        fifo_pop    = '0;
        mask_set    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_d        = rr_q;
        done_mask_d = done_mask_q;
        all_done_d  = 1'b0;
        if (load) begin
            out_valid_d = grant_found;
        end
        if (take) begin
            fifo_pop[grant] = 1'b1;
            out_data_d      = sel_data;
            out_src_d       = grant;
            rr_d            = (grant == SRC_W'(NUM_LEAVES - 1)) ? '0 : grant + 1'b1;
            if (msg_type(sel_data) == MSG_TYPE_DONE) begin
                mask_set = done_mask_q | (NUM_LEAVES'(1) << grant);
                if (&mask_set) begin
                    all_done_d  = 1'b1;
                    done_mask_d = '0;
                end else begin
                    done_mask_d = mask_set;
                end
            end
        end
    end

    // Output stage, arbiter pointer and done-tracker registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_q        <= '0;
            done_mask_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_q        <= rr_d;
            done_mask_q <= done_mask_d;
            all_done_q  <= all_done_d;
        end
    end

`ifdef ROOT_UP_COLLECTOR_STATS_EN
    logic [31:0] stat_msgs_q [NUM_LEAVES];
    logic [31:0] stat_msgs_d [NUM_LEAVES];
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating per-leaf forwarded-message and output-stall counters.
    always_comb begin
        stat_msgs_d  = stat_msgs_q;
        stat_stall_d = stat_stall_q;
        if (take && (stat_msgs_q[grant] != '1)) begin
            stat_msgs_d[grant] = stat_msgs_q[grant] + 32'd1;
        end
        if (out_valid_q && !out_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_msgs_q  <= '{default: '0};
            stat_stall_q <= '0;
        end else begin
            stat_msgs_q  <= stat_msgs_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    for (genvar s = 0; s < NUM_LEAVES; s++) begin : g_stat
        assign stat_msgs[32*s +: 32] = stat_msgs_q[s];
    end
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_root_up_collector.sv
// Directed bench for root_up_collector: reset, single-message latency,
// round-robin streaming and back-pressure via a vector table, DONE rounds,
// and reset with full FIFOs.
module tb_root_up_collector;

    localparam int unsigned NL = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [64*NL-1:0] up_rx_data;
    logic [NL-1:0]   up_rx_valid;
    logic [NL-1:0]   up_rx_ready;
    logic [63:0]     out_data;
    logic [1:0]      out_src;
    logic            out_valid;
    logic            out_ready;
    logic            all_done;
`ifdef ROOT_UP_COLLECTOR_STATS_EN
    logic [32*NL-1:0] stat_msgs;
    logic [31:0]      stat_stall;
`endif

    always #5 clk = ~clk;

    root_up_collector #(
        .NUM_LEAVES    (4),
        .FIFO_DEPTH    (2),
        .MSG_TYPE_DONE (8'hFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .up_rx_data  (up_rx_data),
        .up_rx_valid (up_rx_valid),
        .up_rx_ready (up_rx_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .all_done    (all_done)
`ifdef ROOT_UP_COLLECTOR_STATS_EN
        ,
        .stat_msgs   (stat_msgs),
        .stat_stall  (stat_stall)
`endif
    );

    typedef struct {
        logic       ordy;
        logic       exp_valid;
        logic [1:0] exp_src;
        logic       chk_rdy;
        logic [3:0] exp_rdy;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [47:0] tx_seq [NL];
    logic [47:0] rx_seq [NL];
    logic [NL-1:0] strm;
    bit            sb_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] msg(input int leaf, input logic [47:0] seq);
        return {8'h00, 8'(leaf), seq};
    endfunction

    task automatic drive_streams();
        for (int i = 0; i < NL; i++) begin
            up_rx_valid[i]        = strm[i];
            up_rx_data[64*i +: 64] = msg(i, tx_seq[i]);
        end
    endtask

    // Advance one cycle from a negedge to the next, tracking leaf and output handshakes.
    task automatic tick();
        logic [NL-1:0] acc;
        acc = up_rx_valid & up_rx_ready;
        if (sb_en && out_valid && out_ready) begin
            chk("sb_data", out_data, msg(int'(out_src), rx_seq[out_src]));
            rx_seq[out_src] = rx_seq[out_src] + 48'd1;
        end
        @(negedge clk);
        if (sb_en) begin
            for (int i = 0; i < NL; i++) begin
                if (acc[i]) tx_seq[i] = tx_seq[i] + 48'd1;
            end
            drive_streams();
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        up_rx_valid = '1;
        up_rx_data  = '0;
        out_ready   = 1'b1;
        sb_en       = 1'b0;
        strm        = '0;
        repeat (3) @(negedge clk);
        reset_n     = 1'b1;
        up_rx_valid = '0;
        for (int i = 0; i < NL; i++) begin
            tx_seq[i] = '0;
            rx_seq[i] = '0;
        end
        @(negedge clk);
    endtask

    // One DONE from a leaf; it must appear two edges later with the given all_done.
    task automatic send_done(input int leaf, input logic exp_all);
        up_rx_valid               = NL'(1) << leaf;
        up_rx_data[64*leaf +: 64] = {8'hFF, 56'(leaf)};
        @(negedge clk);
        up_rx_valid = '0;
        @(negedge clk);
        chk("done_valid", 64'(out_valid), 64'd1);
        chk("done_src", 64'(out_src), 64'(leaf));
        chk("done_data", out_data, {8'hFF, 56'(leaf)});
        chk("done_pulse", 64'(all_done), 64'(exp_all));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [18];
        int n;

        for (int k = 0; k < 8; k++) begin
            vecs[k] = '{ordy: 1'b1, exp_valid: 1'b1, exp_src: 2'(k % 4), chk_rdy: 1'b0, exp_rdy: 4'h0};
        end
        for (int k = 8; k < 18; k++) begin
            vecs[k] = '{ordy: 1'b0, exp_valid: 1'b1, exp_src: 2'd0, chk_rdy: (k == 17), exp_rdy: 4'h0};
        end

        // Test 1: reset with all valids high.
        reset_n     = 1'b0;
        up_rx_valid = '1;
        up_rx_data  = '0;
        out_ready   = 1'b1;
        sb_en       = 1'b0;
        strm        = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        reset_n     = 1'b1;
        up_rx_valid = '0;
        @(negedge clk);
        chk("rst_ready", 64'(up_rx_ready), 64'hF);
        chk("rst_idle_valid", 64'(out_valid), 64'd0);

        // Test 2: single message from leaf 2, two-cycle latency.
        up_rx_valid          = 4'b0100;
        up_rx_data[128 +: 64] = 64'h0000_0000_0000_00A5;
        @(negedge clk);
        up_rx_valid = '0;
        chk("lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", out_data, 64'h0000_0000_0000_00A5);
        chk("lat_src", 64'(out_src), 64'd2);
        @(negedge clk);
        chk("lat_gone", 64'(out_valid), 64'd0);

        // Tests 3/4: continuous streaming then 10 stalled cycles, table-driven.
        do_reset();
        sb_en = 1'b1;
        strm  = '1;
        drive_streams();
        tick();
        tick();
        for (int k = 0; k < 18; k++) begin
            out_ready = vecs[k].ordy;
            chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_src", k), 64'(out_src), 64'(vecs[k].exp_src));
            chk($sformatf("vec%0d_data", k), out_data, msg(int'(vecs[k].exp_src), rx_seq[vecs[k].exp_src]));
            if (vecs[k].chk_rdy) begin
                chk($sformatf("vec%0d_ready", k), 64'(up_rx_ready), 64'(vecs[k].exp_rdy));
            end
            tick();
        end
        out_ready = 1'b1;
        strm      = '0;
        drive_streams();
        n = 0;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("drain_bound", 64'(n < 40), 64'd1);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("no_loss_leaf%0d", i), 64'(rx_seq[i]), 64'(tx_seq[i]));
            chk($sformatf("sent_leaf%0d", i), 64'(tx_seq[i] > 48'd3), 64'd1);
        end
        sb_en = 1'b0;

        // Test 5: DONE from 3,1,1,0,2 -> one all_done pulse on leaf 2's DONE.
        do_reset();
        send_done(3, 1'b0);
        send_done(1, 1'b0);
        send_done(1, 1'b0);
        send_done(0, 1'b0);
        send_done(2, 1'b1);
        @(negedge clk);
        chk("done_pulse_end", 64'(all_done), 64'd0);
        chk("done_mask_clr", 64'(dut.done_mask_q), 64'd0);

        // Test 6: reset with full FIFOs and a partial DONE round pending.
        send_done(1, 1'b0);
        @(negedge clk);
        sb_en     = 1'b1;
        strm      = '1;
        out_ready = 1'b0;
        drive_streams();
        repeat (4) tick();
        chk("full_ready", 64'(up_rx_ready), 64'd0);
        reset_n = 1'b0;
        sb_en   = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        reset_n     = 1'b1;
        up_rx_valid = '0;
        out_ready   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", k), 64'(out_valid), 64'd0);
        end
        chk("post_rst_mask", 64'(dut.done_mask_q), 64'd0);
        send_done(0, 1'b0);
        send_done(2, 1'b0);
        send_done(3, 1'b0);
        send_done(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
